// File: rtl/cim_xbar_tile_if.sv
// Crossbar tile access interface.
// Groups the input-buffer write port, weight-cell write port, MVM control
// and column read port between the layer ctrl/func (master) and the tile (slave).
//   i_we/i_wr_addr/i_wr_data      input buffer row write
//   i_w_we/i_w_row/i_w_col/i_w_data weight cell write
//   i_start/o_busy/o_done         MVM control and status
//   i_rd_addr/o_rd_data           registered column result read
interface cim_xbar_tile_if #(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 8
);
  localparam int aw = $clog2(xbar_size);

  logic                     i_we;
  logic [aw-1:0]            i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;
  logic                     i_w_we;
  logic [aw-1:0]            i_w_row;
  logic [aw-1:0]            i_w_col;
  logic                     i_w_data;
  logic                     i_start;
  logic                     o_busy;
  logic                     o_done;
  logic [aw-1:0]            i_rd_addr;
  logic [datatype_size-1:0] o_rd_data;

  modport master (
    output i_we, i_wr_addr, i_wr_data,
    output i_w_we, i_w_row, i_w_col, i_w_data,
    output i_start, i_rd_addr,
    input  o_busy, o_done, o_rd_data
  );

  modport slave (
    input  i_we, i_wr_addr, i_wr_data,
    input  i_w_we, i_w_row, i_w_col, i_w_data,
    input  i_start, i_rd_addr,
    output o_busy, o_done, o_rd_data
  );
endinterface

// File: rtl/cim_xbar_tile.sv
// Behavioural compute-in-memory crossbar tile (responder side).
// Holds an input vector buffer and a 1-bit weight array, runs one
// matrix-vector multiply row by row, and publishes the column results to a
// registered read port.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-low
//   bus  cim_xbar_tile_if.slave (writes, start/busy/done, column read)
// Build option: CIM_XBAR_SAT_EN selects unsigned saturation of column results;
// without it results are truncated to datatype_size bits.
//
// state | meaning
// IDLE  | accepts buffer/weight writes and start
// MAC   | accumulates one weight row per cycle
// WB    | copies converted accumulators into the output buffer, pulses done
module cim_xbar_tile #(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 8
) (
  input  logic            clk,
  input  logic            rst,
  cim_xbar_tile_if.slave  bus
);
  localparam int aw       = $clog2(xbar_size);
  localparam int acc_size = datatype_size + aw;
  localparam logic [aw-1:0] last_row = aw'(xbar_size - 1);

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  state_t state, state_nxt;
  logic   acc_clr, mac_en, wb_en, idle, busy, done;

  logic [aw-1:0]            row;
  logic [datatype_size-1:0] ibuf [xbar_size];
  logic [xbar_size-1:0]     w    [xbar_size];
  logic [acc_size-1:0]      acc  [xbar_size];
  logic [datatype_size-1:0] obuf [xbar_size];
  logic [datatype_size-1:0] rd_data;

  function automatic logic [datatype_size-1:0] conv(input logic [acc_size-1:0] a);
`ifdef CIM_XBAR_SAT_EN
    if (|a[acc_size-1:datatype_size]) return '1;
    else                              return a[datatype_size-1:0];
`else
    return a[datatype_size-1:0];
`endif
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    wb_en     = 1'b0;
    idle      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (bus.i_start) begin
          acc_clr   = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (row == last_row) state_nxt = WB;
      end
      WB: begin
        busy      = 1'b1;
        done      = 1'b1;
        wb_en     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_busy    = busy;
  assign bus.o_done    = done;
  assign bus.o_rd_data = rd_data;

  // Counter holds at the last row; the FSM leaves MAC on that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          row <= '0;
    else if (acc_clr)                  row <= '0;
    else if (mac_en && row != last_row) row <= row + 1'b1;
  end

  // Writes land in IDLE only, so a write coinciding with start is seen by MAC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < xbar_size; i++) ibuf[i] <= '0;
    end else if (idle && bus.i_we) begin
      ibuf[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < xbar_size; i++) w[i] <= '0;
    end else if (idle && bus.i_w_we) begin
      w[bus.i_w_row][bus.i_w_col] <= bus.i_w_data;
    end
  end

  // Accumulator width covers xbar_size full-scale adds, so no internal overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < xbar_size; c++) acc[c] <= '0;
    end else if (acc_clr) begin
      for (int c = 0; c < xbar_size; c++) acc[c] <= '0;
    end else if (mac_en) begin
      for (int c = 0; c < xbar_size; c++)
        if (w[row][c]) acc[c] <= acc[c] + {{aw{1'b0}}, ibuf[row]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < xbar_size; c++) obuf[c] <= '0;
    end else if (wb_en) begin
      for (int c = 0; c < xbar_size; c++) obuf[c] <= conv(acc[c]);
    end
  end

  // Read samples obuf before the WB update lands, so a WB-cycle read sees old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= obuf[bus.i_rd_addr];
  end
endmodule

// File: tb/tb_cim_xbar_tile.sv
module tb_cim_xbar_tile;
  localparam int xbar_size = 128;
  localparam int dt        = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   lat;
  int   d0;

  always #5 clk = ~clk;

  cim_xbar_tile_if #(.xbar_size(xbar_size), .datatype_size(dt)) bus ();

  cim_xbar_tile #(.xbar_size(xbar_size), .datatype_size(dt)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_in(input int addr, input int data);
    bus.i_we      = 1'b1;
    bus.i_wr_addr = 7'(addr);
    bus.i_wr_data = 8'(data);
    tick();
    bus.i_we      = 1'b0;
  endtask

  task automatic wr_w(input int r, input int c);
    bus.i_w_we   = 1'b1;
    bus.i_w_row  = 7'(r);
    bus.i_w_col  = 7'(c);
    bus.i_w_data = 1'b1;
    tick();
    bus.i_w_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Returns the number of cycles from the start edge to the done cycle.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.o_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic read_col(input int c, input string tag, input int exp);
    bus.i_rd_addr = 7'(c);
    tick();
    check_val(tag, 32'(bus.o_rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    bus.i_we = 0; bus.i_wr_addr = 0; bus.i_wr_data = 0;
    bus.i_w_we = 0; bus.i_w_row = 0; bus.i_w_col = 0; bus.i_w_data = 0;
    bus.i_start = 0; bus.i_rd_addr = 0;

    tick(); tick();
    check_val("rst_busy", 32'(bus.o_busy), 0);
    check_val("rst_done", 32'(bus.o_done), 0);
    check_val("rst_rd",   32'(bus.o_rd_data), 0);
    rst = 1'b1;
    tick();

    // identity: both write ports in the same cycle
    for (int r = 0; r < xbar_size; r++) begin
      bus.i_we = 1; bus.i_wr_addr = 7'(r); bus.i_wr_data = 8'(r);
      bus.i_w_we = 1; bus.i_w_row = 7'(r); bus.i_w_col = 7'(r); bus.i_w_data = 1;
      tick();
    end
    bus.i_we = 0; bus.i_w_we = 0;
    d0 = done_cnt;
    pulse_start();
    check_val("id_busy_t1", 32'(bus.o_busy), 1);
    wait_done(lat);
    check_val("id_latency", 32'(lat), 128);
    check_val("id_busy_wb", 32'(bus.o_busy), 1);
    tick();
    check_val("id_busy_end", 32'(bus.o_busy), 0);
    check_val("id_done_cnt", 32'(done_cnt - d0), 1);
    read_col(7, "id_col7", 7);
    read_col(0, "id_col0", 0);
    read_col(127, "id_col127", 127);

    // column sum
    do_reset();
    for (int r = 0; r < 4; r++) begin
      wr_w(r, 2);
      wr_in(r, 10 * (r + 1));
    end
    pulse_start();
    wait_done(lat);
    tick();
    read_col(2, "cs_col2", 100);
    read_col(0, "cs_col0", 0);
    read_col(3, "cs_col3", 0);
    read_col(127, "cs_col127", 0);

    // second MVM: new data, read during busy, dropped write/start
    wr_in(3, 50);
    d0 = done_cnt;
    bus.i_rd_addr = 7'd2;
    pulse_start();
    repeat (50) tick();
    check_val("busy_rd_col2", 32'(bus.o_rd_data), 100);
    bus.i_we = 1; bus.i_wr_addr = 7'd0; bus.i_wr_data = 8'd99; bus.i_start = 1;
    tick();
    bus.i_we = 0; bus.i_start = 0;
    wait_done(lat);
    check_val("mvm2_latency", 32'(lat), 128 - 51);
    check_val("wb_rd_prev", 32'(bus.o_rd_data), 100);
    tick();
    check_val("wb_rd_old", 32'(bus.o_rd_data), 100);
    check_val("mvm2_busy_end", 32'(bus.o_busy), 0);
    tick();
    check_val("wb_rd_new", 32'(bus.o_rd_data), 110);
    repeat (150) tick();
    check_val("drop_done_cnt", 32'(done_cnt - d0), 1);

    // third MVM: write coincident with start is used; earlier dropped write is not
    bus.i_we = 1; bus.i_wr_addr = 7'd1; bus.i_wr_data = 8'd5; bus.i_start = 1;
    tick();
    bus.i_we = 0; bus.i_start = 0;
    wait_done(lat);
    check_val("mvm3_latency", 32'(lat), 128);
    tick();
    read_col(2, "wr_start_col2", 95);

    // overflow
    do_reset();
    wr_w(0, 0); wr_w(1, 0);
    wr_in(0, 200); wr_in(1, 100);
    pulse_start();
    wait_done(lat);
    tick();
`ifdef CIM_XBAR_SAT_EN
    read_col(0, "ovf_col0", 255);
`else
    read_col(0, "ovf_col0", 44);
`endif

    // reset mid-MAC
    d0 = done_cnt;
    pulse_start();
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check_val("midrst_busy", 32'(bus.o_busy), 0);
    check_val("midrst_done", 32'(bus.o_done), 0);
    tick(); tick();
    rst = 1'b1;
    repeat (200) tick();
    check_val("midrst_no_done", 32'(done_cnt - d0), 0);
    read_col(5, "midrst_col5", 0);
    read_col(0, "midrst_col0", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
